// File: rtl/idex_stage_reg.sv
// Decode->execute pipeline register: resolves forwarded operands, inserts load-use bubbles,
// and runs a valid/ready handshake with flush. Optional perf counters behind IDEX_PERF_EN.
module idex_stage_reg #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REGW   = 5,
  parameter int unsigned CTLW   = 16,
  parameter int unsigned PERF_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [REGW-1:0] in_ra1,
  input  logic [REGW-1:0] in_ra2,
  input  logic [XLEN-1:0] in_rd1,
  input  logic [XLEN-1:0] in_rd2,
  input  logic            fwd_a_en,
  input  logic [XLEN-1:0] fwd_a_data,
  input  logic            fwd_b_en,
  input  logic [XLEN-1:0] fwd_b_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [REGW-1:0] in_dst,
  input  logic [CTLW-1:0] in_ctl,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_srca,
  output logic [XLEN-1:0] out_srcb,
  output logic [XLEN-1:0] out_imm,
  output logic [REGW-1:0] out_dst,
  output logic [CTLW-1:0] out_ctl,
`ifdef IDEX_PERF_EN
  output logic [PERF_W-1:0] perf_bubbles,
  output logic [PERF_W-1:0] perf_holds,
`endif
  output logic            load_use
);

  logic            slotFree;
  logic            accept;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;

  // x0 is hard-wired zero, so it is never forwarded.
  always_comb begin
    srcA = in_rd1;
    srcB = in_rd2;
    if (in_ra1 == '0)  srcA = '0;
    else if (fwd_a_en) srcA = fwd_a_data;
    if (in_ra2 == '0)  srcB = '0;
    else if (fwd_b_en) srcB = fwd_b_data;
  end

  always_comb begin
    load_use = in_valid & out_valid & out_ctl[1] & (out_dst != '0)
             & ((out_dst == in_ra1) | (out_dst == in_ra2));
    slotFree = ~out_valid | out_ready;
    in_ready = slotFree & ~load_use & ~flush;
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_srca  <= '0;
      out_srcb  <= '0;
      out_imm   <= '0;
      out_dst   <= '0;
      out_ctl   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctl   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_srca  <= srcA;
      out_srcb  <= srcB;
      out_imm   <= in_imm;
      out_dst   <= in_dst;
      out_ctl   <= in_ctl;
    end else if (slotFree) begin
      out_valid <= 1'b0;
      out_ctl   <= '0;
    end
  end

`ifdef IDEX_PERF_EN
  logic bubbleEvt;
  logic holdEvt;

  always_comb begin
    bubbleEvt = ~flush & ~accept & slotFree & in_valid;
    holdEvt   = ~flush & ~accept & ~slotFree;
  end

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_bubbles <= '0;
      perf_holds   <= '0;
    end else begin
      if (bubbleEvt && (perf_bubbles != '1)) perf_bubbles <= perf_bubbles + 1'b1;
      if (holdEvt && (perf_holds != '1))     perf_holds   <= perf_holds + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg: directed vector table plus hand-written
// hold, flush, back-to-back and reset-mid-stall sequences.
module tb_idex_stage_reg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned REGW = 5;
  localparam int unsigned CTLW = 16;
  localparam int unsigned PERF_W = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [REGW-1:0] in_ra1;
  logic [REGW-1:0] in_ra2;
  logic [XLEN-1:0] in_rd1;
  logic [XLEN-1:0] in_rd2;
  logic            fwd_a_en;
  logic [XLEN-1:0] fwd_a_data;
  logic            fwd_b_en;
  logic [XLEN-1:0] fwd_b_data;
  logic [XLEN-1:0] in_imm;
  logic [REGW-1:0] in_dst;
  logic [CTLW-1:0] in_ctl;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_srca;
  logic [XLEN-1:0] out_srcb;
  logic [XLEN-1:0] out_imm;
  logic [REGW-1:0] out_dst;
  logic [CTLW-1:0] out_ctl;
  logic            load_use;
`ifdef IDEX_PERF_EN
  logic [PERF_W-1:0] perf_bubbles;
  logic [PERF_W-1:0] perf_holds;
`endif

  always #5 clk = ~clk;

  idex_stage_reg #(
    .XLEN  (XLEN),
    .REGW  (REGW),
    .CTLW  (CTLW),
    .PERF_W(PERF_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_ra1    (in_ra1),
    .in_ra2    (in_ra2),
    .in_rd1    (in_rd1),
    .in_rd2    (in_rd2),
    .fwd_a_en  (fwd_a_en),
    .fwd_a_data(fwd_a_data),
    .fwd_b_en  (fwd_b_en),
    .fwd_b_data(fwd_b_data),
    .in_imm    (in_imm),
    .in_dst    (in_dst),
    .in_ctl    (in_ctl),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_srca  (out_srca),
    .out_srcb  (out_srcb),
    .out_imm   (out_imm),
    .out_dst   (out_dst),
    .out_ctl   (out_ctl),
`ifdef IDEX_PERF_EN
    .perf_bubbles(perf_bubbles),
    .perf_holds  (perf_holds),
`endif
    .load_use  (load_use)
  );

  typedef struct {
    logic            valid;
    logic [REGW-1:0] ra1;
    logic [REGW-1:0] ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            faEn;
    logic [XLEN-1:0] fa;
    logic            fbEn;
    logic [XLEN-1:0] fb;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] dst;
    logic [CTLW-1:0] ctl;
    logic            fl;
    logic            oRdy;
    logic            expLoadUse;
    logic            expInReady;
    logic            expValid;
    logic [XLEN-1:0] expSrcA;
    logic [XLEN-1:0] expSrcB;
    logic [XLEN-1:0] expPc;
    logic [CTLW-1:0] expCtl;
  } vec_t;

  vec_t vecs[9];
  int   passCnt = 0;
  int   totalCnt = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.valid;
    in_ra1     = v.ra1;
    in_ra2     = v.ra2;
    in_rd1     = v.rd1;
    in_rd2     = v.rd2;
    fwd_a_en   = v.faEn;
    fwd_a_data = v.fa;
    fwd_b_en   = v.fbEn;
    fwd_b_data = v.fb;
    in_pc      = v.pc;
    in_imm     = v.pc + 64'h1000;
    in_dst     = v.dst;
    in_ctl     = v.ctl;
    flush      = v.fl;
    out_ready  = v.oRdy;
  endtask

  // Inputs change 1ns after the edge; registered outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic valid, input logic [REGW-1:0] ra1,
                              input logic [REGW-1:0] ra2, input logic [XLEN-1:0] pc,
                              input logic [REGW-1:0] dst, input logic [CTLW-1:0] ctl);
    vec_t v;
    v = '{default: '0};
    v.valid = valid; v.ra1 = ra1; v.ra2 = ra2; v.pc = pc; v.dst = dst; v.ctl = ctl;
    v.oRdy = 1'b1;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Forwarding over rf read on ra1; plain read on ra2.
    v = mk(1, 5, 6, 64'h100, 3, 16'h1);
    v.rd1 = 64'h11; v.faEn = 1; v.fa = 64'hAA; v.rd2 = 64'h22;
    v.expInReady = 1; v.expValid = 1; v.expSrcA = 64'hAA; v.expSrcB = 64'h22;
    v.expPc = 64'h100; v.expCtl = 16'h1;
    vecs[0] = v;
    // x0 never forwarded.
    v = mk(1, 0, 0, 64'h104, 4, 16'h1);
    v.rd1 = 64'h33; v.faEn = 1; v.fa = 64'hBB; v.fbEn = 1; v.fb = 64'hCC; v.rd2 = 64'h34;
    v.expInReady = 1; v.expValid = 1; v.expPc = 64'h104; v.expCtl = 16'h1;
    vecs[1] = v;
    // Load to x7.
    v = mk(1, 2, 3, 64'h108, 7, 16'h2);
    v.rd1 = 64'h44; v.fbEn = 1; v.fb = 64'h55; v.rd2 = 64'h66;
    v.expInReady = 1; v.expValid = 1; v.expSrcA = 64'h44; v.expSrcB = 64'h55;
    v.expPc = 64'h108; v.expCtl = 16'h2;
    vecs[2] = v;
    // Consumer of x7: one bubble, fields other than valid/ctl hold.
    v = mk(1, 1, 7, 64'h10C, 8, 16'h1);
    v.rd1 = 64'h77; v.fbEn = 1; v.fb = 64'h99;
    v.expLoadUse = 1; v.expInReady = 0; v.expValid = 0; v.expSrcA = 64'h44;
    v.expSrcB = 64'h55; v.expPc = 64'h108; v.expCtl = 16'h0;
    vecs[3] = v;
    // Same consumer now accepted.
    v = vecs[3];
    v.expLoadUse = 0; v.expInReady = 1; v.expValid = 1; v.expSrcA = 64'h77;
    v.expSrcB = 64'h99; v.expPc = 64'h10C; v.expCtl = 16'h1;
    vecs[4] = v;
    // Idle: slot drains.
    v = mk(0, 0, 0, 64'hDEAD, 0, 16'h0);
    v.expInReady = 1; v.expValid = 0; v.expSrcA = 64'h77; v.expSrcB = 64'h99;
    v.expPc = 64'h10C; v.expCtl = 16'h0;
    vecs[5] = v;
    // Load with dst=x0.
    v = mk(1, 9, 10, 64'h110, 0, 16'h3);
    v.rd1 = 64'h1; v.rd2 = 64'h2;
    v.expInReady = 1; v.expValid = 1; v.expSrcA = 64'h1; v.expSrcB = 64'h2;
    v.expPc = 64'h110; v.expCtl = 16'h3;
    vecs[6] = v;
    // Reads x0 after load to x0: no hazard.
    v = mk(1, 0, 0, 64'h114, 2, 16'h1);
    v.rd1 = 64'h5; v.rd2 = 64'h6;
    v.expInReady = 1; v.expValid = 1; v.expPc = 64'h114; v.expCtl = 16'h1;
    vecs[7] = v;
    // Flush drops incoming.
    v = mk(1, 1, 1, 64'h118, 2, 16'h1);
    v.fl = 1; v.rd1 = 64'h9;
    v.expInReady = 0; v.expValid = 0; v.expPc = 64'h114; v.expCtl = 16'h0;
    vecs[8] = v;

    // Reset.
    reset_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0));
    #12;
    check("rst_valid", {63'b0, out_valid}, 64'h0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_ctl", {48'b0, out_ctl}, 64'h0);
    check("rst_srca", out_srca, 64'h0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_load_use", i), {63'b0, load_use}, {63'b0, vecs[i].expLoadUse});
      check($sformatf("v%0d_in_ready", i), {63'b0, in_ready}, {63'b0, vecs[i].expInReady});
      tick();
      check($sformatf("v%0d_valid", i), {63'b0, out_valid}, {63'b0, vecs[i].expValid});
      check($sformatf("v%0d_srca", i), out_srca, vecs[i].expSrcA);
      check($sformatf("v%0d_srcb", i), out_srcb, vecs[i].expSrcB);
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].expPc);
      check($sformatf("v%0d_ctl", i), {48'b0, out_ctl}, {48'b0, vecs[i].expCtl});
    end

    // Hold: accept pc 0x200 with E stalled, then three held edges with new input pending.
    v = mk(1, 4, 0, 64'h200, 6, 16'h1);
    v.faEn = 1; v.fa = 64'hABC; v.oRdy = 0;
    drive(v);
    tick();
    check("hold_accept_pc", out_pc, 64'h200);
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 4, 0, 64'h204, 9, 16'h1);
      v.faEn = 1; v.fa = 64'h123 + i; v.oRdy = 0;
      drive(v);
      #1;
      check($sformatf("hold%0d_in_ready", i), {63'b0, in_ready}, 64'h0);
      tick();
      check($sformatf("hold%0d_valid", i), {63'b0, out_valid}, 64'h1);
      check($sformatf("hold%0d_pc", i), out_pc, 64'h200);
      check($sformatf("hold%0d_srca", i), out_srca, 64'hABC);
    end
`ifdef IDEX_PERF_EN
    check("perf_holds", {32'b0, perf_holds}, 64'd3);
    check("perf_bubbles", {32'b0, perf_bubbles}, 64'd1);
`endif

    // Flush with a held entry and a new valid input.
    v = mk(1, 1, 1, 64'h300, 3, 16'h1);
    v.fl = 1; v.oRdy = 0;
    drive(v);
    tick();
    check("flush_valid", {63'b0, out_valid}, 64'h0);
    check("flush_ctl", {48'b0, out_ctl}, 64'h0);
    check("flush_pc", out_pc, 64'h200);

    // Back-to-back independent instructions.
    for (int i = 0; i < 8; i++) begin
      v = mk(1, 1, 2, 64'h400 + 64'(4 * i), 3, 16'h1);
      drive(v);
      #1;
      check($sformatf("b2b%0d_in_ready", i), {63'b0, in_ready}, 64'h1);
      tick();
      check($sformatf("b2b%0d_valid", i), {63'b0, out_valid}, 64'h1);
      check($sformatf("b2b%0d_pc", i), out_pc, 64'h400 + 64'(4 * i));
    end

    // Simultaneous flush and load-use: flush wins, no bubble counted.
    drive(mk(1, 1, 2, 64'h500, 5, 16'h2));
    tick();
    v = mk(1, 5, 0, 64'h504, 6, 16'h1);
    v.fl = 1;
    drive(v);
    #1;
    check("fl_lu_load_use", {63'b0, load_use}, 64'h1);
    check("fl_lu_in_ready", {63'b0, in_ready}, 64'h0);
    tick();
    check("fl_lu_valid", {63'b0, out_valid}, 64'h0);
    check("fl_lu_pc", out_pc, 64'h500);
`ifdef IDEX_PERF_EN
    check("fl_lu_perf_bubbles", {32'b0, perf_bubbles}, 64'd1);
`endif

    // Reset mid-stall: load held by E, consumer waiting.
    v = mk(1, 1, 2, 64'h600, 5, 16'h2);
    v.rd1 = 64'hF00;
    drive(v);
    tick();
    v = mk(1, 5, 0, 64'h604, 6, 16'h1);
    v.oRdy = 0;
    drive(v);
    #1;
    check("stall_in_ready", {63'b0, in_ready}, 64'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {63'b0, out_valid}, 64'h0);
    check("midrst_ctl", {48'b0, out_ctl}, 64'h0);
    check("midrst_srca", out_srca, 64'h0);
    tick();
    reset_n = 1'b1;
    #1;
    check("postrst_in_ready", {63'b0, in_ready}, 64'h1);
`ifdef IDEX_PERF_EN
    check("postrst_perf_holds", {32'b0, perf_holds}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
